// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int OP_W = 8;
  localparam int P_W  = 16;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap.
module rr_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    // last_grant < N_REQ, so one conditional subtract is a full modulo
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant = (enable && found) ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one pipelined 8x8 multiplier among N_REQ requesters.
//   state   | meaning
//   ST_IDLE | no operation in flight; grant the next valid requester
//   ST_WAIT | operands registered; count down the multiplier latency
//   ST_RESP | product held on rsp_* until the consumer accepts it
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [OP_W-1:0]       mul_a,
  output logic [OP_W-1:0]       mul_b,
  input  logic [P_W-1:0]        mul_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [P_W-1:0]        rsp_p,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int LAT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  id_reg;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant;
  logic [LAT_W-1:0] wait_cnt;

  // Grant is suppressed during reset so req_ready reads zero while clr is high
  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     ((state == ST_IDLE) && !clr),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_IDLE;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_p      <= '0;
      ops_done   <= '0;
      id_reg     <= '0;
      wait_cnt   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            mul_a      <= req_a[OP_W*grant_idx +: OP_W];
            mul_b      <= req_b[OP_W*grant_idx +: OP_W];
            id_reg     <= grant_idx;
            last_grant <= grant_idx;
            wait_cnt   <= LAT_W'(MUL_LAT);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_p     <= mul_p;
            rsp_id    <= id_reg;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one 8x8 add-tree multiplier between N_REQ requesters.
- Per-requester valid/ready operand ports; round-robin grant; one operation in flight.
- Registers operands to the multiplier, waits the multiplier's fixed latency, samples the 16-bit product and returns it with the requester ID over a single valid/ready response port.
- Sits between the operand sources (switch front-end, test sequencer) and the shared add_tree datapath, which runs on the same clock.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= N_REQ
MUL_LAT, 1, register stages inside the multiplier between mul_a/mul_b and a valid mul_p
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  single clock, shared with the multiplier
clr  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  requester i has operands pending
req_a  in  8*N_REQ  multiplicand of requester i in bits [8i+7:8i]
req_b  in  8*N_REQ  multiplier of requester i in bits [8i+7:8i]
req_ready  out  N_REQ  one-hot accept; the handshake completes on req_valid[i] & req_ready[i]
mul_a  out  8  registered operand to the shared multiplier
mul_b  out  8  registered operand to the shared multiplier
mul_p  in  16  product from the shared multiplier
rsp_valid  out  1  rsp_p/rsp_id valid
rsp_ready  in  1  consumer accepts the response
rsp_id  out  ID_W  index of the requester that owns rsp_p
rsp_p  out  16  product a*b, unsigned
busy  out  1  high in every state except IDLE
ops_done  out  CNT_W  count of completed response handshakes; wraps modulo 2**CNT_W

Behaviour:
- Clock and reset: one clock (clk); reset clr is asynchronous and active-high.
- Reset values (clr=1, immediate): state IDLE; mul_a=0; mul_b=0; rsp_valid=0; rsp_id=0; rsp_p=0; ops_done=0; busy=0; req_ready=0; last_grant=N_REQ-1, so requester 0 has first priority.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. Requesters re-present their operands after reset.
- FSM states: IDLE, WAIT, RESP. Encoding is 2-bit binary.
- IDLE:
  - grant g = first i with req_valid[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready is combinational: one-hot at g only in IDLE with any req_valid, else all zero.
  - At the edge: mul_a <= req_a[g], mul_b <= req_b[g], id_reg <= g, last_grant <= g, wait counter <= MUL_LAT, go to WAIT.
  - If no req_valid, stay in IDLE; outputs hold.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter is 0, at the edge: rsp_p <= mul_p, rsp_id <= id_reg, rsp_valid <= 1, go to RESP.
  - Latency: accept at edge T gives rsp_valid=1 after edge T+1+MUL_LAT. For MUL_LAT=1 that is 2 edges.
  - mul_a/mul_b hold their values through WAIT and RESP.
- RESP:
  - rsp_valid, rsp_p and rsp_id are stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge: rsp_valid <= 0, ops_done <= ops_done+1, go to IDLE.
  - A new grant can occur in the next IDLE cycle. Minimum spacing between accepts is MUL_LAT+3 cycles.
- Back-pressure: rsp_ready low holds the FSM in RESP indefinitely, and no new request is accepted.
- Requester rule: req_valid[i] stays high with stable operands until its req_ready[i] handshake. If req_valid drops before the grant, nothing is recorded.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,... No requester waits more than N_REQ-1 other operations.
- Simultaneous events: when several requesters are valid in the same IDLE cycle, round-robin alone decides the grant. A req_valid rising during WAIT or RESP is only considered in the next IDLE.
- Arithmetic: the product is unsigned 8x8 -> 16 bits. The arbiter does not modify mul_p; it samples it.
- ops_done wraps from 2**CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package/include holds:
  - state encodings: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2
  - OP_W=8, P_W=16
- Sub-module rr_arbiter (N_REQ parameter): inputs req vector, last_grant and enable; outputs one-hot grant and its index. It is purely combinational.
- The FSM, operand registers and counters stay in mult_arbiter.
- The bench instantiates the existing add_tree multiplier on clk for mul_a/mul_b/mul_p.

Test Plan:
1. Reset, then req_valid=4'b0001 with a=25, b=12, rsp_ready=1 -> req_ready[0] for one cycle; rsp_valid 2 edges after accept; rsp_id=0, rsp_p=300; ops_done=1.
2. All four valid continuously, requester i using a=i+1, b=200, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_p = 200,400,600,800,200; accepts spaced exactly MUL_LAT+3 cycles apart.
3. Boundary operands a=255, b=255; then a=0, b=177 -> rsp_p=65025; then rsp_p=0.
4. Requester 2 with a=13, b=11, rsp_ready held low 10 cycles -> rsp_valid stays high with rsp_p=143 and rsp_id=2 stable; req_ready stays 0 despite req_valid[1]=1; after rsp_ready rises, requester 1 is granted next.
5. Assert clr during WAIT -> rsp_valid, ops_done, mul_a and mul_b are 0 immediately; no response appears; after release, requester 0 wins over requester 3 when both are valid.
6. With CNT_W=4, run 17 operations -> ops_done ends at 1.
